// File: rtl/rv_pkg.sv
// Shared RV32I types and constants used by the register file, ALU and control decoder.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

  localparam reg_addr_t X0 = 5'd0;
  localparam reg_addr_t RA = 5'd1;
  localparam reg_addr_t SP = 5'd2;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus: two read ports, one write port, debug read and write counter.
interface reg_file_if #(
  parameter int unsigned XLEN = rv_pkg::XLEN
);
  import rv_pkg::*;

  logic            WE3;
  reg_addr_t       A1;
  reg_addr_t       A2;
  reg_addr_t       A3;
  logic [XLEN-1:0] WD3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  reg_addr_t       DA;
  logic [XLEN-1:0] DRD;
  logic [31:0]     wr_cnt;

  modport master (
    output WE3, A1, A2, A3, WD3, DA,
    input  RD1, RD2, DRD, wr_cnt
  );

  modport slave (
    input  WE3, A1, A2, A3, WD3, DA,
    output RD1, RD2, DRD, wr_cnt
  );

endinterface

// File: rtl/reg_file_rdport.sv
// One combinational read port: x0 forced to zero, optional write-through when
// REG_FILE_WRITE_BYPASS_EN is defined.
module reg_file_rdport
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
`ifdef REG_FILE_WRITE_BYPASS_EN
  input  logic                      we,
  input  reg_addr_t                 wa,
  input  logic [XLEN-1:0]           wd,
`endif
  input  reg_addr_t                 addr,
  input  logic [NREG-1:0][XLEN-1:0] regs,
  output logic [XLEN-1:0]           rd
);

  always_comb begin
    rd = '0;
    if (addr != X0) begin
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (we && (wa == addr)) rd = wd;
      else                    rd = regs[addr];
`else
      rd = regs[addr];
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN RV32I integer register file with committed-write counter.
// Optional same-cycle write-through: define REG_FILE_WRITE_BYPASS_EN.
module reg_file
  import rv_pkg::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    NREG      = 32,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  logic [XLEN-1:0]           mem [1:NREG-1];
  logic [NREG-1:0][XLEN-1:0] view;
  logic [31:0]               wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i < NREG; i++) mem[i] <= RESET_VAL;
      wr_cnt_q <= '0;
    end else if (bus.WE3 && (bus.A3 != X0)) begin
      mem[bus.A3] <= bus.WD3;
      wr_cnt_q    <= wr_cnt_q + 32'd1;
    end
  end

  // Slot 0 has no storage; it is tied to zero so the ports can index uniformly.
  always_comb begin
    view = '0;
    for (int unsigned i = 1; i < NREG; i++) view[i] = mem[i];
  end

  assign bus.wr_cnt = wr_cnt_q;

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic byp_we;
  // Bypass is held off in reset so reads still show the reset contents.
  assign byp_we = bus.WE3 & rst;

  reg_file_rdport #(.XLEN(XLEN), .NREG(NREG)) u_rd1 (
    .we(byp_we), .wa(bus.A3), .wd(bus.WD3), .addr(bus.A1), .regs(view), .rd(bus.RD1));
  reg_file_rdport #(.XLEN(XLEN), .NREG(NREG)) u_rd2 (
    .we(byp_we), .wa(bus.A3), .wd(bus.WD3), .addr(bus.A2), .regs(view), .rd(bus.RD2));
  reg_file_rdport #(.XLEN(XLEN), .NREG(NREG)) u_drd (
    .we(byp_we), .wa(bus.A3), .wd(bus.WD3), .addr(bus.DA), .regs(view), .rd(bus.DRD));
`else
  reg_file_rdport #(.XLEN(XLEN), .NREG(NREG)) u_rd1 (
    .addr(bus.A1), .regs(view), .rd(bus.RD1));
  reg_file_rdport #(.XLEN(XLEN), .NREG(NREG)) u_rd2 (
    .addr(bus.A2), .regs(view), .rd(bus.RD2));
  reg_file_rdport #(.XLEN(XLEN), .NREG(NREG)) u_drd (
    .addr(bus.DA), .regs(view), .rd(bus.DRD));
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (either REG_FILE_WRITE_BYPASS_EN build).
module tb_reg_file;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // reset held with a pending write: nothing may commit
    rst      = 1'b0;
    bus.WE3  = 1'b1;
    bus.A3   = 5'd5;
    bus.WD3  = 32'hDEAD_BEEF;
    bus.A1   = 5'd5;
    bus.A2   = 5'd0;
    bus.DA   = 5'd5;
    #2;
    check("rst_rd1", bus.RD1, 32'h0);
    check("rst_cnt", bus.wr_cnt, 32'h0);
    check("rst_drd", bus.DRD, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_hold_rd1", bus.RD1, 32'h0);
      check("rst_hold_cnt", bus.wr_cnt, 32'h0);
    end
    rst = 1'b1;
    step();
    check("rel_rd1", bus.RD1, 32'hDEAD_BEEF);
    check("rel_cnt", bus.wr_cnt, 32'd1);

    // x0 write is discarded
    bus.A3  = 5'd0;
    bus.WD3 = 32'hFFFF_FFFF;
    bus.A1  = 5'd0;
    bus.A2  = 5'd0;
    bus.DA  = 5'd0;
    step();
    check("x0_rd1", bus.RD1, 32'h0);
    check("x0_rd2", bus.RD2, 32'h0);
    check("x0_drd", bus.DRD, 32'h0);
    check("x0_cnt", bus.wr_cnt, 32'd1);

    // dual read
    bus.A3 = 5'd7; bus.WD3 = 32'h0000_1234; step();
    bus.A3 = 5'd8; bus.WD3 = 32'h8000_0000; step();
    bus.WE3 = 1'b0;
    bus.A1 = 5'd7; bus.A2 = 5'd8;
    #1;
    check("dual_rd1", bus.RD1, 32'h0000_1234);
    check("dual_rd2", bus.RD2, 32'h8000_0000);
    bus.A1 = 5'd8;
    #1;
    check("same_rd1", bus.RD1, 32'h8000_0000);
    check("same_rd2", bus.RD2, 32'h8000_0000);
    check("dual_cnt", bus.wr_cnt, 32'd3);

    // same-cycle read/write
    bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h11; step();
    bus.WD3 = 32'h22; bus.A1 = 5'd3; bus.DA = 5'd3;
    #1;
`ifdef REG_FILE_WRITE_BYPASS_EN
    check("rw_pre_rd1", bus.RD1, 32'h22);
    check("rw_pre_drd", bus.DRD, 32'h22);
`else
    check("rw_pre_rd1", bus.RD1, 32'h11);
    check("rw_pre_drd", bus.DRD, 32'h11);
`endif
    step();
    bus.WE3 = 1'b0;
    #1;
    check("rw_post_rd1", bus.RD1, 32'h22);
    check("rw_cnt", bus.wr_cnt, 32'd5);

    // WE3=0 hold, then X on idle inputs
    bus.A3 = 5'd9; bus.WD3 = 32'hAAAA_AAAA;
    for (int i = 0; i < 4; i++) step();
    bus.A3 = 'x; bus.WD3 = 'x;
    step();
    bus.A1 = 5'd9; bus.A2 = 5'd3;
    #1;
    check("hold_x9", bus.RD1, 32'h0);
    check("hold_x3", bus.RD2, 32'h22);
    check("hold_cnt", bus.wr_cnt, 32'd5);

    // asynchronous reset mid-cycle with a write pending
    bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h55;
    rst = 1'b0;
    #1;
    check("async_x3", bus.RD2, 32'h0);
    check("async_cnt", bus.wr_cnt, 32'h0);
    step();
    check("async_hold_x3", bus.RD2, 32'h0);
    rst = 1'b1;

    // sweep x1..x31
    for (int i = 1; i < 32; i++) begin
      bus.A3  = 5'(i);
      bus.WD3 = 32'(i);
      step();
    end
    bus.WE3 = 1'b0;
    check("sweep_cnt", bus.wr_cnt, 32'd31);
    for (int i = 0; i < 32; i++) begin
      bus.A1 = 5'(i);
      bus.A2 = 5'(31 - i);
      bus.DA = 5'(i);
      #1;
      check("sweep_rd1", bus.RD1, 32'(i));
      check("sweep_rd2", bus.RD2, 32'(31 - i));
      check("sweep_drd", bus.DRD, 32'(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
